// File: rtl/memory_controller_q.sv
// Dual-queue memory controller: FIFO write/read request queues, single-issue
// arbitration with write-before-read hazard protection, fixed-latency returns.
module memory_controller_q #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned MEM_AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] wr_ret_address,
    output logic              wr_ret_ack,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_address,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_ret_data,
    output logic [ADDR_W-1:0] rd_ret_address,
    output logic              rd_ret_ack
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned LAST = LATENCY - 1;
    localparam int unsigned MEMN = 2 ** MEM_AW;

    logic [ADDR_W-1:0] r_wq_addr [DEPTH];
    logic [DATA_W-1:0] r_wq_data [DEPTH];
    logic [PW-1:0]     r_wq_wp, r_wq_rp;
    logic [CW-1:0]     r_wq_cnt;
    logic [ADDR_W-1:0] r_rq_addr [DEPTH];
    logic [PW-1:0]     r_rq_wp, r_rq_rp;
    logic [CW-1:0]     r_rq_cnt;
    logic              r_alive;

    logic [DATA_W-1:0] r_mem [MEMN];

    logic              r_pv [LATENCY];
    logic              r_pw [LATENCY];
    logic [ADDR_W-1:0] r_pa [LATENCY];
    logic [DATA_W-1:0] r_pd [LATENCY];

    logic              r_wr_ack, r_rd_ack;
    logic [ADDR_W-1:0] r_wr_ret_addr, r_rd_ret_addr;
    logic [DATA_W-1:0] r_rd_ret_data;

    logic              w_wr_acc, w_rd_acc;
    logic              w_wq_full, w_wq_empty, w_rq_empty;
    logic              w_conflict, w_wr_issue, w_rd_issue;
    logic [ADDR_W-1:0] w_wq_head_addr, w_rq_head_addr;
    logic [DATA_W-1:0] w_wq_head_data;

    assign wr_ready = r_alive && (r_wq_cnt < CW'(DEPTH));
    assign rd_ready = r_alive && (r_rq_cnt < CW'(DEPTH));
    assign w_wr_acc = wr_en && wr_ready;
    assign w_rd_acc = rd_en && rd_ready;

    assign w_wq_full      = (r_wq_cnt == CW'(DEPTH));
    assign w_wq_empty     = (r_wq_cnt == '0);
    assign w_rq_empty     = (r_rq_cnt == '0);
    assign w_wq_head_addr = r_wq_addr[r_wq_rp];
    assign w_wq_head_data = r_wq_data[r_wq_rp];
    assign w_rq_head_addr = r_rq_addr[r_rq_rp];

    // Entry i is live when its distance from the read pointer is below the count.
    always_comb begin
        w_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(PW'(i) - r_wq_rp)} < r_wq_cnt) && (r_wq_addr[i] == w_rq_head_addr))
                w_conflict = 1'b1;
        end
    end

    assign w_wr_issue = !w_wq_empty && (w_wq_full || w_rq_empty || w_conflict);
    assign w_rd_issue = !w_rq_empty && !w_wr_issue;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_wq_addr[r_wq_wp] <= wr_address;
            r_wq_data[r_wq_wp] <= wr_data;
        end
        if (w_rd_acc)
            r_rq_addr[r_rq_wp] <= rd_address;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive  <= 1'b0;
            r_wq_wp  <= '0;
            r_wq_rp  <= '0;
            r_wq_cnt <= '0;
            r_rq_wp  <= '0;
            r_rq_rp  <= '0;
            r_rq_cnt <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_wr_acc)   r_wq_wp <= r_wq_wp + PW'(1);
            if (w_wr_issue) r_wq_rp <= r_wq_rp + PW'(1);
            if (w_rd_acc)   r_rq_wp <= r_rq_wp + PW'(1);
            if (w_rd_issue) r_rq_rp <= r_rq_rp + PW'(1);
            r_wq_cnt <= r_wq_cnt + CW'(w_wr_acc) - CW'(w_wr_issue);
            r_rq_cnt <= r_rq_cnt + CW'(w_rd_acc) - CW'(w_rd_issue);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MEMN; i++)
                r_mem[i] <= '0;
        end else if (w_wr_issue) begin
            r_mem[w_wq_head_addr[MEM_AW-1:0]] <= w_wq_head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pw[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_wr_issue || w_rd_issue;
            r_pw[0] <= w_wr_issue;
            r_pa[0] <= w_wr_issue ? w_wq_head_addr : w_rq_head_addr;
            r_pd[0] <= w_wr_issue ? w_wq_head_data : r_mem[w_rq_head_addr[MEM_AW-1:0]];
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pw[i] <= r_pw[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    // Return registers add the final cycle, so issue-to-ack is exactly LATENCY edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ack      <= 1'b0;
            r_rd_ack      <= 1'b0;
            r_wr_ret_addr <= '0;
            r_rd_ret_addr <= '0;
            r_rd_ret_data <= '0;
        end else begin
            r_wr_ack <= r_pv[LAST] && r_pw[LAST];
            r_rd_ack <= r_pv[LAST] && !r_pw[LAST];
            if (r_pv[LAST] && r_pw[LAST])
                r_wr_ret_addr <= r_pa[LAST];
            if (r_pv[LAST] && !r_pw[LAST]) begin
                r_rd_ret_addr <= r_pa[LAST];
                r_rd_ret_data <= r_pd[LAST];
            end
        end
    end

    assign wr_ret_ack     = r_wr_ack;
    assign rd_ret_ack     = r_rd_ack;
    assign wr_ret_address = r_wr_ret_addr;
    assign rd_ret_address = r_rd_ret_addr;
    assign rd_ret_data    = r_rd_ret_data;

endmodule

// File: tb/tb_memory_controller_q.sv
// Directed and randomised checks of memory_controller_q (default instance plus a
// DEPTH=2/LATENCY=1 instance), with per-channel expected-return queues.
module tb_memory_controller_q;
    logic        clk;
    logic        rst_n;
    int          cyc;
    int          n_checks;
    int          n_errors;

    logic        wr_en, rd_en, wr_ready, rd_ready, wr_ret_ack, rd_ret_ack;
    logic [15:0] wr_address, wr_data, rd_address, wr_ret_address, rd_ret_address, rd_ret_data;

    logic        w2_en, r2_en, w2_ready, r2_ready, w2_ack, r2_ack;
    logic [15:0] w2_addr, w2_data, r2_addr, w2_ret_addr, r2_ret_addr, r2_ret_data;

    logic [15:0] exp_wa[$], exp_ra[$], exp_rd[$];
    logic [15:0] e2_wa[$], e2_ra[$], e2_rd[$];
    logic [15:0] model2 [32];
    int          wr_ack_cyc, rd_ack_cyc, w2_ack_cyc, acc_cyc;

    memory_controller_q dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .wr_ready(wr_ready),
        .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
        .rd_en(rd_en), .rd_address(rd_address), .rd_ready(rd_ready),
        .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack)
    );

    memory_controller_q #(.DEPTH(2), .LATENCY(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(w2_en), .wr_address(w2_addr), .wr_data(w2_data), .wr_ready(w2_ready),
        .wr_ret_address(w2_ret_addr), .wr_ret_ack(w2_ack),
        .rd_en(r2_en), .rd_address(r2_addr), .rd_ready(r2_ready),
        .rd_ret_data(r2_ret_data), .rd_ret_address(r2_ret_addr), .rd_ret_ack(r2_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wr_ret_ack || rd_ret_ack)
            check("both_acks", 32'(wr_ret_ack && rd_ret_ack), 0);
        if (wr_ret_ack) begin
            check("wr_ack_expected", 32'(exp_wa.size() > 0), 1);
            if (exp_wa.size() > 0) check("wr_ret_address", wr_ret_address, exp_wa.pop_front());
            wr_ack_cyc = cyc;
        end
        if (rd_ret_ack) begin
            check("rd_ack_expected", 32'(exp_ra.size() > 0), 1);
            if (exp_ra.size() > 0) begin
                check("rd_ret_address", rd_ret_address, exp_ra.pop_front());
                check("rd_ret_data", rd_ret_data, exp_rd.pop_front());
            end
            rd_ack_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (w2_ack || r2_ack)
            check("d2_both_acks", 32'(w2_ack && r2_ack), 0);
        if (w2_ack) begin
            check("d2_wr_ack_expected", 32'(e2_wa.size() > 0), 1);
            if (e2_wa.size() > 0) check("d2_wr_ret_address", w2_ret_addr, e2_wa.pop_front());
            w2_ack_cyc = cyc;
        end
        if (r2_ack) begin
            check("d2_rd_ack_expected", 32'(e2_ra.size() > 0), 1);
            if (e2_ra.size() > 0) begin
                check("d2_rd_ret_address", r2_ret_addr, e2_ra.pop_front());
                check("d2_rd_ret_data", r2_ret_data, e2_rd.pop_front());
            end
        end
    end

    task automatic req(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                       input bit re, input logic [15:0] ra, input logic [15:0] rexp);
        bit wpend = we;
        bit rpend = re;
        bit aw, ar;
        int unsigned n = 0;
        while ((wpend || rpend) && n < 50) begin
            wr_en = wpend; wr_address = wa; wr_data = wd;
            rd_en = rpend; rd_address = ra;
            aw = wpend && wr_ready;
            ar = rpend && rd_ready;
            @(posedge clk); #1;
            if (aw) begin exp_wa.push_back(wa); wpend = 1'b0; acc_cyc = cyc; end
            if (ar) begin exp_ra.push_back(ra); exp_rd.push_back(rexp); rpend = 1'b0; acc_cyc = cyc; end
            n++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("req_accepted", {30'd0, wpend, rpend}, 0);
    endtask

    task automatic req2(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                        input bit re, input logic [15:0] ra, input logic [15:0] rexp);
        bit wpend = we;
        bit rpend = re;
        bit aw, ar;
        int unsigned n = 0;
        while ((wpend || rpend) && n < 50) begin
            w2_en = wpend; w2_addr = wa; w2_data = wd;
            r2_en = rpend; r2_addr = ra;
            aw = wpend && w2_ready;
            ar = rpend && r2_ready;
            @(posedge clk); #1;
            if (aw) begin e2_wa.push_back(wa); wpend = 1'b0; acc_cyc = cyc; end
            if (ar) begin e2_ra.push_back(ra); e2_rd.push_back(rexp); rpend = 1'b0; acc_cyc = cyc; end
            n++;
        end
        w2_en = 1'b0; r2_en = 1'b0;
        check("d2_req_accepted", {30'd0, wpend, rpend}, 0);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((exp_wa.size() + exp_ra.size() + e2_wa.size() + e2_ra.size()) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", exp_wa.size() + exp_ra.size() + e2_wa.size() + e2_ra.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rlist [5];
        int          ri;
        int          t0;
        bit          aw, ar;

        cyc = 0; n_checks = 0; n_errors = 0;
        wr_ack_cyc = 0; rd_ack_cyc = 0; w2_ack_cyc = 0; acc_cyc = 0;
        rst_n = 1'b0;
        wr_en = 0; rd_en = 0; wr_address = '0; wr_data = '0; rd_address = '0;
        w2_en = 0; r2_en = 0; w2_addr = '0; w2_data = '0; r2_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_acks", {wr_ret_ack, rd_ret_ack}, 0);
        check("rst_rd_ret_data", rd_ret_data, 0);
        check("rst_d2_ready", {w2_ready, r2_ready}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {wr_ready, rd_ready}, 2'b11);

        // Basic write then read, exact latency
        req(1, 16'h0012, 16'hBEEF, 0, '0, '0);
        t0 = acc_cyc;
        wait_idle();
        check("wr_latency", wr_ack_cyc - t0, 5);
        req(0, '0, '0, 1, 16'h0012, 16'hBEEF);
        t0 = acc_cyc;
        wait_idle();
        check("rd_latency", rd_ack_cyc - t0, 5);
        check("rd_hold_data", rd_ret_data, 16'hBEEF);
        check("rd_hold_addr", rd_ret_address, 16'h0012);
        check("rd_ack_low_idle", rd_ret_ack, 0);

        // Same-edge write and read to one address: write wins
        req(1, 16'h0005, 16'h1234, 1, 16'h0005, 16'h1234);
        wait_idle();
        check("rd_after_wr", rd_ack_cyc - wr_ack_cyc, 1);

        // Read queue fills while a write stream to the head address stalls it
        for (int i = 1; i < 5; i++) req(1, 16'(16'h0040 + i), 16'(16'hC040 + i), 0, '0, '0);
        wait_idle();
        for (int i = 0; i < 5; i++) rlist[i] = 16'(16'h0040 + i);
        ri = 0;
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1; wr_address = 16'h0040; wr_data = 16'(16'h5000 + k);
            rd_en = (k >= 1); rd_address = rlist[ri];
            if (k == 5) begin
                check("rd_ready_full", rd_ready, 0);
                check("rd_accepted_before_full", ri, 4);
                check("wr_ready_stream", wr_ready, 1);
            end
            aw = wr_ready;
            ar = rd_en && rd_ready;
            @(posedge clk); #1;
            if (aw) exp_wa.push_back(16'h0040);
            if (ar) begin
                exp_ra.push_back(rlist[ri]);
                exp_rd.push_back(ri == 0 ? 16'h5007 : 16'(16'hC040 + ri));
                ri++;
            end
        end
        req(0, '0, '0, 1, 16'h0044, 16'hC044);
        wait_idle();

        // Index aliasing
        req(1, 16'h0100, 16'hAAAA, 0, '0, '0);
        wait_idle();
        req(0, '0, '0, 1, 16'h0100, 16'hAAAA);
        req(0, '0, '0, 1, 16'h0000, 16'hAAAA);
        wait_idle();

        // Reset with three requests in flight
        req(1, 16'h0077, 16'h7777, 0, '0, '0);
        req(0, '0, '0, 1, 16'h0012, 16'hBEEF);
        req(1, 16'h0030, 16'h3030, 0, '0, '0);
        rst_n = 1'b0;
        #2;
        check("midrst_ready", {wr_ready, rd_ready}, 0);
        check("midrst_acks", {wr_ret_ack, rd_ret_ack}, 0);
        check("midrst_wr_ret_addr", wr_ret_address, 0);
        check("midrst_rd_ret_data", rd_ret_data, 0);
        exp_wa.delete(); exp_ra.delete(); exp_rd.delete();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_ready_held", {wr_ready, rd_ready}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midrst", {wr_ready, rd_ready}, 2'b11);
        repeat (10) @(posedge clk);
        #1;
        req(0, '0, '0, 1, 16'h0012, 16'h0000);
        req(0, '0, '0, 1, 16'h0077, 16'h0000);
        req(0, '0, '0, 1, 16'h0041, 16'h0000);
        wait_idle();

        // DEPTH=2, LATENCY=1 instance: preload read region, then random traffic
        req2(1, 16'h0020, 16'hA520, 0, '0, '0);
        t0 = acc_cyc;
        wait_idle();
        check("d2_wr_latency", w2_ack_cyc - t0, 2);
        for (int a = 16'h21; a < 16'h40; a++) req2(1, 16'(a), 16'(16'hA500 | a), 0, '0, '0);
        wait_idle();
        for (int i = 0; i < 32; i++) model2[i] = '0;
        for (int k = 0; k < 300; k++) begin
            w2_en = 1'($urandom_range(0, 1));
            w2_addr = 16'($urandom_range(0, 31));
            w2_data = 16'($urandom);
            r2_en = 1'($urandom_range(0, 1));
            r2_addr = 16'(16'h0020 + $urandom_range(0, 31));
            aw = w2_en && w2_ready;
            ar = r2_en && r2_ready;
            @(posedge clk); #1;
            if (aw) begin e2_wa.push_back(w2_addr); model2[w2_addr[4:0]] = w2_data; end
            if (ar) begin e2_ra.push_back(r2_addr); e2_rd.push_back(16'hA500 | r2_addr); end
        end
        w2_en = 1'b0; r2_en = 1'b0;
        wait_idle();
        for (int a = 0; a < 32; a++) req2(0, '0, '0, 1, 16'(a), model2[a]);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
